// File: rtl/ccip_rd_rsp_pkg.sv
// Shared CCI-P channel 0 types, the queued request entry and the line data generator
// used by the channel 0 read responder.
package ccip_rd_rsp_pkg;

    typedef logic [41:0]  t_ccip_clAddr;
    typedef logic [15:0]  t_ccip_mdata;
    typedef logic [511:0] t_ccip_clData;
    typedef logic [1:0]   t_ccip_clLen;
    typedef logic [1:0]   t_line_idx;

    typedef enum logic [1:0] {
        eVC_VA  = 2'b00,
        eVC_VL0 = 2'b01,
        eVC_VH0 = 2'b10,
        eVC_VH1 = 2'b11
    } t_ccip_vc;

    typedef enum logic [3:0] {
        eREQ_RDLINE_I = 4'h0,
        eREQ_RDLINE_S = 4'h1
    } t_ccip_c0_req;

    typedef enum logic [3:0] {
        eRSP_RDLINE = 4'h0,
        eRSP_UMSG   = 4'h4
    } t_ccip_c0_rsp;

    localparam t_ccip_clLen CL_LEN_RSVD = 2'b10;

    typedef struct packed {
        t_ccip_vc     vc_sel;
        logic [1:0]   rsvd1;
        t_ccip_clLen  cl_len;
        t_ccip_c0_req req_type;
        logic [5:0]   rsvd0;
        t_ccip_clAddr address;
        t_ccip_mdata  mdata;
    } t_ccip_c0_ReqMemHdr;

    typedef struct packed {
        t_ccip_c0_ReqMemHdr hdr;
        logic               valid;
    } t_if_ccip_c0_Tx;

    typedef struct packed {
        t_ccip_vc     vc_used;
        logic         rsvd1;
        logic         hit_miss;
        logic         format;
        logic         rsvd0;
        t_line_idx    cl_num;
        t_ccip_c0_rsp resp_type;
        t_ccip_mdata  mdata;
    } t_ccip_c0_RspMemHdr;

    typedef struct packed {
        t_ccip_c0_RspMemHdr hdr;
        t_ccip_clData       data;
        logic               rspValid;
        logic               mmioRdValid;
        logic               mmioWrValid;
    } t_if_ccip_c0_Rx;

    typedef struct packed {
        t_ccip_clAddr address;
        t_ccip_mdata  mdata;
        t_ccip_vc     vc_sel;
        t_ccip_clLen  cl_len;
    } t_rd_req_entry;

    function automatic t_ccip_clData rd_rsp_data(input t_ccip_clAddr line_addr,
                                                 input logic [63:0]  seed);
        return {8{64'(line_addr) ^ seed}};
    endfunction

endpackage

// File: rtl/ccip_rd_rsp_req_fifo.sv
// Show-ahead request queue for the channel 0 read responder; exports current and
// next-cycle occupancy so the top can register its almost-full flag without lag.
module ccip_rd_rsp_req_fifo
    import ccip_rd_rsp_pkg::*;
#(
    parameter int REQ_FIFO_DEPTH_RADIX = 5
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          i_push,
    input  t_rd_req_entry                 i_din,
    input  logic                          i_pop,
    output t_rd_req_entry                 o_head,
    output logic                          o_empty,
    output logic                          o_full,
    output logic [REQ_FIFO_DEPTH_RADIX:0] o_count,
    output logic [REQ_FIFO_DEPTH_RADIX:0] o_count_nxt
);

    localparam int DEPTH = 1 << REQ_FIFO_DEPTH_RADIX;
    localparam logic [REQ_FIFO_DEPTH_RADIX:0]   FULL_LEVEL = (REQ_FIFO_DEPTH_RADIX+1)'(DEPTH);
    localparam logic [REQ_FIFO_DEPTH_RADIX:0]   CNT_ONE    = 1;
    localparam logic [REQ_FIFO_DEPTH_RADIX-1:0] PTR_ONE    = 1;

    t_rd_req_entry                   r_mem [DEPTH];
    logic [REQ_FIFO_DEPTH_RADIX-1:0] r_wr_ptr;
    logic [REQ_FIFO_DEPTH_RADIX-1:0] r_rd_ptr;
    logic [REQ_FIFO_DEPTH_RADIX:0]   r_count;
    logic                            w_push;
    logic                            w_pop;

    // A pop in the same cycle does not free a slot for a push into a full queue.
    assign w_push = i_push && (r_count != FULL_LEVEL);
    assign w_pop  = i_pop && (r_count != '0);

    always_comb begin
        o_count_nxt = r_count;
        if (w_push && !w_pop) begin
            o_count_nxt = r_count + CNT_ONE;
        end else if (!w_push && w_pop) begin
            o_count_nxt = r_count - CNT_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
            r_count <= o_count_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= i_din;
    end

    assign o_head  = r_mem[r_rd_ptr];
    assign o_empty = (r_count == '0);
    assign o_full  = (r_count == FULL_LEVEL);
    assign o_count = r_count;

endmodule

// File: rtl/ccip_c0_rd_responder.sv
// CCI-P channel 0 read responder: queues AFU reads and returns address-derived lines.
// Define CCIP_RD_RSP_LINE_REVERSE_EN to emit multi-line responses highest cl_num first.
module ccip_c0_rd_responder
    import ccip_rd_rsp_pkg::*;
#(
    parameter int          REQ_FIFO_DEPTH_RADIX = 5,
    parameter int          ALM_FULL_THRESHOLD   = 8,
    parameter logic [63:0] DATA_SEED            = 64'h0
) (
    input  logic           clk,
    input  logic           reset,
    input  t_if_ccip_c0_Tx c0Tx,
    output t_if_ccip_c0_Rx c0Rx,
    output logic           c0TxAlmFull,
    output logic           err_overflow,
    output logic           err_cl_len
);

    localparam int DEPTH = 1 << REQ_FIFO_DEPTH_RADIX;
    localparam logic [REQ_FIFO_DEPTH_RADIX:0] ALM_LEVEL =
        (REQ_FIFO_DEPTH_RADIX+1)'(DEPTH - ALM_FULL_THRESHOLD);
    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_EMIT = 1'b1;

    logic [0:0]                    r_state;
    t_line_idx                     r_line_cnt;
    logic                          r_alm_full;
    logic                          r_err_overflow;
    logic                          r_err_cl_len;
    t_if_ccip_c0_Rx                r_rsp_p1;

    t_rd_req_entry                 w_req;
    t_rd_req_entry                 w_head;
    t_if_ccip_c0_Rx                w_rsp;
    logic                          w_empty;
    logic                          w_full;
    logic                          w_emit;
    logic                          w_last;
    logic                          w_pop;
    logic [REQ_FIFO_DEPTH_RADIX:0] w_count;
    logic [REQ_FIFO_DEPTH_RADIX:0] w_count_nxt;
    t_line_idx                     w_cl_num;
    t_ccip_clAddr                  w_line_addr;
    logic                          w_unused;

    assign w_req = '{address: c0Tx.hdr.address, mdata: c0Tx.hdr.mdata,
                     vc_sel: c0Tx.hdr.vc_sel, cl_len: c0Tx.hdr.cl_len};

    ccip_rd_rsp_req_fifo #(.REQ_FIFO_DEPTH_RADIX(REQ_FIFO_DEPTH_RADIX)) u_req_fifo (
        .clk        (clk),
        .reset      (reset),
        .i_push     (c0Tx.valid),
        .i_din      (w_req),
        .i_pop      (w_pop),
        .o_head     (w_head),
        .o_empty    (w_empty),
        .o_full     (w_full),
        .o_count    (w_count),
        .o_count_nxt(w_count_nxt)
    );

    // cl_len is N-1 for every encoding, so it doubles as the last line index.
    assign w_emit = (r_state == ST_EMIT);
    assign w_last = (r_line_cnt == w_head.cl_len);
    assign w_pop  = w_emit && w_last;

`ifdef CCIP_RD_RSP_LINE_REVERSE_EN
    assign w_cl_num = w_head.cl_len - r_line_cnt;
`else
    assign w_cl_num = r_line_cnt;
`endif

    assign w_line_addr = w_head.address + t_ccip_clAddr'(w_cl_num);

    always_comb begin
        w_rsp               = '0;
        w_rsp.rspValid      = 1'b1;
        w_rsp.hdr.resp_type = eRSP_RDLINE;
        w_rsp.hdr.mdata     = w_head.mdata;
        w_rsp.hdr.cl_num    = w_cl_num;
        w_rsp.hdr.vc_used   = (w_head.vc_sel == eVC_VA) ? eVC_VL0 : w_head.vc_sel;
        w_rsp.data          = rd_rsp_data(w_line_addr, DATA_SEED);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_line_cnt <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (!w_empty) r_state <= ST_EMIT;
                end
                default: begin
                    if (w_last) begin
                        r_line_cnt <= '0;
                        if (w_count_nxt == '0) r_state <= ST_IDLE;
                    end else begin
                        r_line_cnt <= r_line_cnt + 2'd1;
                    end
                end
            endcase
        end
    end

    // Output stage: one registered response beat per EMIT cycle.
    always_ff @(posedge clk) begin
        if (reset || !w_emit) begin
            r_rsp_p1 <= '0;
        end else begin
            r_rsp_p1 <= w_rsp;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_alm_full     <= 1'b0;
            r_err_overflow <= 1'b0;
            r_err_cl_len   <= 1'b0;
        end else begin
            r_alm_full <= (w_count_nxt >= ALM_LEVEL);
            if (c0Tx.valid && w_full)                       r_err_overflow <= 1'b1;
            if (c0Tx.valid && c0Tx.hdr.cl_len == CL_LEN_RSVD) r_err_cl_len   <= 1'b1;
        end
    end

    assign w_unused = ^{w_count, c0Tx.hdr.req_type, c0Tx.hdr.rsvd0, c0Tx.hdr.rsvd1};

    assign c0Rx         = r_rsp_p1;
    assign c0TxAlmFull  = r_alm_full;
    assign err_overflow = r_err_overflow;
    assign err_cl_len   = r_err_cl_len;

endmodule
